tcb_dec_pipe: RTL
=================

// Module: tcb_dec_pipe
// PURPOSE
//  Address decoder for the Tightly Coupled Bus (TCB): one subordinate port fans out to PN manager ports.
//  Supports pipelined response delay DLY>=0 with one transfer per cycle and DLY responses outstanding.
//  A per-stage select pipeline steers each response back from the port that accepted its request.
//  Sits between a CPU/DMA manager and peripheral/memory subordinates.
// PARAMETERS
//  AW   32               address width
//  DW   32               data width; BW=DW/8 byte enables
//  PN   2                number of manager ports, 1..16
//  DLY  1                fixed response delay in cycles, 0..4, equal on sub and all man ports
//  AS   PN x AW 'x       per-port address pattern, wildcard match (==?), x bits = don't care
// PORTS
//  sub.clk     input   1       clock (shared by all interfaces)
//  sub.rst     input   1       reset, synchronous, active-high
//  sub.vld     input   1       request valid
//  sub.wen     input   1       write enable
//  sub.ben     input   BW      byte enables
//  sub.adr     input   AW      address
//  sub.wdt     input   DW      write data
//  sub.rdt     output  DW      read data, response phase
//  sub.err     output  1       error, response phase
//  sub.rdy     output  1       ready, request phase
//  man[i].*    mirror  -       same signal set, opposite directions, i=0..PN-1
// BEHAVIOUR
//  - Transfer: trn = vld & rdy on sub. Match vector: hit[i] = sub.adr ==? AS[i]. Lowest matching index wins.
//  - Request: man[sel].vld = sub.vld and wen/ben/adr/wdt are forwarded. Other ports: vld=0, remaining fields 0.
//  - sub.rdy = man[sel].rdy, combinational. No register in the request path.
//  - Select pipeline: DLY stages of {act, sel}. Stage 0 loads {trn, sel} every cycle; stages shift each cycle unconditionally.
//  - Response: DLY=0 uses sel directly. DLY>0 uses stage DLY-1. If act=1, sub.rdt/err are taken from man[sel_resp]. If act=0, rdt=0 and err=0.
//  - A response from a port is never routed unless that port accepted a request exactly DLY cycles earlier.
//  - Back-to-back transfers to different ports on consecutive cycles each return on the correct port, in order.
//  - No match: see CONFIGURATION. Without the macro the request goes to port PN-1 (catch-all).
//  - Reset (sub.rst=1 at clk edge): all pipeline act=0, sel=0, and in-flight responses are discarded.
//    While rst is high: man[*].vld=0, sub.rdt=0, sub.err=0; sub.rdy follows the default port's rdy.
//  - Reset mid-operation: responses arriving up to DLY cycles after reset deassertion are masked (act=0).
//  - Elaboration: $error if PN>16, if DLY>4, or if sub/man AW, DW, BW or DLY differ.
// CONFIGURATION
//  Macro TCB_DEC_PIPE_DEFAULT_ERR_EN.
//  Defined: an unmatched address is accepted by an internal error responder.
//   - rdy=1 and no man port sees vld.
//   - After DLY cycles, sub.err=1 and sub.rdt=0.
//   - The select encoding gains index PN, so the select width becomes $clog2(PN+1).
//  Undefined: unmatched addresses route to port PN-1 and no internal responder is built.
// STRUCTURE
//  tcb_pkg: tcb_dec_sel_t is a packed struct {logic act; logic [SW-1:0] sel;}. Also holds SW computation function, DLY_MAX=4, PN_MAX=16.
//  Sub-module tcb_dec_sel_pipe:
//   - Parametrised DLY and SW shift register with sync reset.
//   - DLY=0 is a combinational pass-through.
//  Top instantiates the pipeline. Decode, request fan-out and response mux are generate loops over an indexable array.
// TESTING
//  Setup: PN=3, DLY=1, AS={32'h2xxx_xxxx, 32'h1xxx_xxxx, 32'h0xxx_xxxx}.
//  1. Read 0x0000_0010, man0 rdt=0xCAFE_0001 -> sub.rdt=0xCAFE_0001 one cycle after trn; man1 and man2 vld=0.
//  2. Back-to-back reads 0x1000_0000 then 0x2000_0000, man1 rdt=0x11, man2 rdt=0x22 -> sub.rdt 0x11 then 0x22 on consecutive cycles.
//  3. man1.rdy=0 for 3 cycles with a request to 0x1000_0004 -> sub.rdy=0 for 3 cycles; one response only, after rdy rises.
//  4. Access 0x3000_0000 with macro defined -> sub.rdy=1, no man vld, sub.err=1 and rdt=0 one cycle later.
//     Without the macro -> man2 receives the request.
//  5. Assert rst in the cycle after a trn to man0 -> no response observed; sub.err=0, sub.rdt=0 for 2 cycles.
//  6. Rerun tests 1-2 with DLY=0 and with DLY=3 -> responses appear at the same cycle and at +3 cycles respectively.

Source files
------------

// File: rtl/tcb_dec_pipe_pkg.sv
// tcb_dec_pipe_pkg: shared types, limits and select sizing for the TCB pipelined decoder.
// Build macro TCB_DEC_PIPE_DEFAULT_ERR_EN adds an internal error responder as select index PN.
package tcb_dec_pipe_pkg;

    localparam int DLY_MAX = 4;
    localparam int PN_MAX  = 16;

`ifdef TCB_DEC_PIPE_DEFAULT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Struct is sized for the largest legal PN so one type serves every instance
    localparam int SW_MAX = $clog2(PN_MAX + 1);

    typedef struct packed {
        logic              act;
        logic [SW_MAX-1:0] sel;
    } tcb_dec_sel_t;

    function automatic int sel_width(input int pn);
        int n;
        n = ERR_EN ? pn + 1 : pn;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcb_dec_sel_pipe.sv
// tcb_dec_sel_pipe: DLY-deep shift register of {act, sel} with sync reset.
// DLY=0 degenerates into a combinational pass-through.
module tcb_dec_sel_pipe #(
    parameter int DLY = 1,
    parameter int SW  = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [SW:0] din,
    output logic [SW:0] dout
);

    if (DLY == 0) begin : g_comb
        assign dout = din;
    end else begin : g_reg
        logic [SW:0] stg [DLY];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DLY; k++) stg[k] <= '0;
            end else begin
                stg[0] <= din;
                for (int k = 1; k < DLY; k++) stg[k] <= stg[k-1];
            end
        end
        assign dout = stg[DLY-1];
    end

endmodule

// File: rtl/tcb_dec_pipe.sv
// tcb_dec_pipe: TCB address decoder, one subordinate port fanned out to PN manager ports.
// Define TCB_DEC_PIPE_DEFAULT_ERR_EN to answer unmatched addresses with err instead of port PN-1.
module tcb_dec_pipe
    import tcb_dec_pipe_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int PN  = 2,
    parameter int DLY = 1,
    parameter logic [PN-1:0][AW-1:0] AS = {PN{{AW{1'bx}}}},
    localparam int BW = DW / 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sub_vld,
    input  logic                   sub_wen,
    input  logic [BW-1:0]          sub_ben,
    input  logic [AW-1:0]          sub_adr,
    input  logic [DW-1:0]          sub_wdt,
    output logic [DW-1:0]          sub_rdt,
    output logic                   sub_err,
    output logic                   sub_rdy,
    output logic [PN-1:0]          man_vld,
    output logic [PN-1:0]          man_wen,
    output logic [PN-1:0][BW-1:0]  man_ben,
    output logic [PN-1:0][AW-1:0]  man_adr,
    output logic [PN-1:0][DW-1:0]  man_wdt,
    input  logic [PN-1:0][DW-1:0]  man_rdt,
    input  logic [PN-1:0]          man_err,
    input  logic [PN-1:0]          man_rdy
);

    localparam int SW  = sel_width(PN);
    localparam int DEF = ERR_EN ? PN : PN - 1;

    if (PN < 1 || PN > PN_MAX) begin : g_bad_pn
        $error("tcb_dec_pipe: PN=%0d outside 1..%0d", PN, PN_MAX);
    end
    if (DLY < 0 || DLY > DLY_MAX) begin : g_bad_dly
        $error("tcb_dec_pipe: DLY=%0d outside 0..%0d", DLY, DLY_MAX);
    end
    if (DW % 8 != 0) begin : g_bad_dw
        $error("tcb_dec_pipe: DW=%0d is not a whole number of bytes", DW);
    end

    logic [PN-1:0]         hit;
    logic [SW-1:0]         sel;
    logic [PN-1:0]         rdy_v;
    logic                  trn;
    logic                  rsp_act;
    logic                  rsp_err;
    tcb_dec_sel_t          req;
    tcb_dec_sel_t          rsp;
    logic [PN-1:0][DW-1:0] rdt_v;
    logic [PN-1:0]         err_v;

    for (genvar i = 0; i < PN; i++) begin : g_port
        assign hit[i]     = sub_adr ==? AS[i];
        assign man_vld[i] = !rst && sub_vld && sel == SW'(i);
        assign man_wen[i] = (sel == SW'(i)) ? sub_wen : 1'b0;
        assign man_ben[i] = (sel == SW'(i)) ? sub_ben : '0;
        assign man_adr[i] = (sel == SW'(i)) ? sub_adr : '0;
        assign man_wdt[i] = (sel == SW'(i)) ? sub_wdt : '0;
        assign rdy_v[i]   = sel == SW'(i) && man_rdy[i];
        assign rdt_v[i]   = (rsp_act && rsp.sel == SW_MAX'(i)) ? man_rdt[i] : '0;
        assign err_v[i]   = rsp_act && rsp.sel == SW_MAX'(i) && man_err[i];
    end

    // Lowest matching index wins; reset parks the select on the default target
    always_comb begin
        sel = SW'(DEF);
        for (int i = PN - 1; i >= 0; i--) sel = (hit[i] && !rst) ? SW'(i) : sel;
    end

`ifdef TCB_DEC_PIPE_DEFAULT_ERR_EN
    // Unmatched requests are absorbed locally and answered with err after DLY cycles
    assign sub_rdy = (sel == SW'(PN)) || (|rdy_v);
    assign rsp_err = rsp_act && rsp.sel == SW_MAX'(PN);
`else
    assign sub_rdy = |rdy_v;
    assign rsp_err = 1'b0;
`endif

    assign trn     = sub_vld && sub_rdy && !rst;
    assign req     = '{act: trn, sel: SW_MAX'(sel)};
    assign rsp_act = rsp.act && !rst;

    tcb_dec_sel_pipe #(
        .DLY (DLY),
        .SW  (SW_MAX)
    ) u_sel_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (req),
        .dout (rsp)
    );

    always_comb begin
        sub_rdt = '0;
        sub_err = rsp_err;
        for (int i = 0; i < PN; i++) begin
            sub_rdt = sub_rdt | rdt_v[i];
            sub_err = sub_err | err_v[i];
        end
    end

endmodule
